switch_debouncer: RTL and testbench

//   Input conditioner that sits between the raw board DIP switches and the counter stage.
//   - Synchronises WIDTH asynchronous switch lines into clk.
//   - Per-bit debounce: a bit changes only after it holds a new level for DEBOUNCE_CYCLES cycles.
//   - sw_clean drives the counter's DPSwitch input; per-bit rise/fall strobes go to edge-triggered logic.

---
 rtl/switch_debouncer_pkg.sv | 16 +
 rtl/switch_debouncer_if.sv | 25 ++
 rtl/switch_debouncer_debounce_bit.sv | 53 +++++
 rtl/switch_debouncer.sv | 46 ++++
 tb/tb_switch_debouncer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared constants and status type for the switch conditioner, the counter stage
// and their benches.
package switch_debounce_pkg;

  localparam int SW_WIDTH            = 8;
  localparam int DEBOUNCE_CYCLES_HW  = 100000;  // 1 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_SIM = 8;

  typedef struct packed {
    logic [SW_WIDTH-1:0] clean;
    logic [SW_WIDTH-1:0] rise;
    logic [SW_WIDTH-1:0] fall;
    logic                changed;
  } sw_status_t;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bundle between the board pins and the conditioner. The master side drives
// raw levels and consumes the conditioned levels and strobes.
interface switch_debouncer_if
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
) ();

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_raw,
    input  sw_clean, sw_rise, sw_fall, sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean, sw_rise, sw_fall, sw_changed
  );

endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One debounce channel: two-flop synchroniser, stability counter, clean level and
// registered rise/fall strobes.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic change_nxt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             qualify;

  // The new level has now differed from clean on DEBOUNCE_CYCLES consecutive edges.
  assign qualify    = (sync2 != clean) && (cnt == CNT_MAX);
  assign change_nxt = qualify;

  // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking
  // here would let sync2 see this edge's sync1 and shorten the synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= qualify &  sync2;
      fall  <= qualify & ~sync2;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (qualify) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Conditions WIDTH asynchronous DIP switch lines: per-bit synchronise and debounce,
// plus a combined change strobe aligned with the per-bit strobes.
module switch_debouncer
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
  input  logic                clk,
  input  logic                reset,
  switch_debouncer_if.slave   sw
);

  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] change_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .raw        (sw.sw_raw[i]),
      .clean      (clean[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .change_nxt (change_nxt[i])
    );
  end

  assign sw.sw_clean = clean;
  assign sw.sw_rise  = rise;
  assign sw.sw_fall  = fall;

  // Built from the next-state strobes so it lands on the same edge as rise/fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw.sw_changed <= 1'b0;
    end else begin
      sw.sw_changed <= |change_nxt;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity, every
// cycle scored against a sliding-window model of the debounce rule.
module tb_switch_debouncer;
  import switch_debounce_pkg::*;

  localparam int W = SW_WIDTH;
  localparam int N = DEBOUNCE_CYCLES_SIM;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  switch_debouncer_if #(.WIDTH(W)) sw_if ();

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic sw_status_t observe();
    sw_status_t o;
    o.clean   = sw_if.sw_clean;
    o.rise    = sw_if.sw_rise;
    o.fall    = sw_if.sw_fall;
    o.changed = sw_if.sw_changed;
    return o;
  endfunction

  // Reference model: a bit adopts a new level once the synchronised samples seen on
  // the last N edges all disagree with its current clean level. The synchronised
  // sample on an edge is the raw level captured two edges earlier.
  sw_status_t   exp_q[$];
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] s2_hist[$];
  logic [W-1:0] clean_m = '0;

  always @(posedge clk) begin
    sw_status_t   e;
    logic [W-1:0] s2;
    logic         all_diff;
    e = '0;
    if (!reset) begin
      raw_hist.delete();
      s2_hist.delete();
      clean_m = '0;
    end else begin
      s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
      s2_hist.push_back(s2);
      if (s2_hist.size() > N) void'(s2_hist.pop_front());
      for (int b = 0; b < W; b++) begin
        all_diff = (s2_hist.size() == N);
        foreach (s2_hist[i]) if (s2_hist[i][b] == clean_m[b]) all_diff = 1'b0;
        if (all_diff) begin
          clean_m[b] = ~clean_m[b];
          if (clean_m[b]) e.rise[b] = 1'b1;
          else            e.fall[b] = 1'b1;
        end
      end
      raw_hist.push_back(sw_if.sw_raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      e.clean   = clean_m;
      e.changed = |(e.rise | e.fall);
    end
    exp_q.push_back(e);
  end

  // Monitor: the DUT presents a status word every cycle; score it just after the edge.
  initial begin
    sw_status_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("cycle_status", 32'(observe()), 32'(e));
      end
    end
  end

  int rise0_cnt = 0;
  int chg_cnt   = 0;
  always @(negedge clk) begin
    if (sw_if.sw_rise[0]) rise0_cnt++;
    if (sw_if.sw_changed) chg_cnt++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] mask;

    // Start-up with every switch already high.
    sw_if.sw_raw = 8'hFF;
    reset        = 1'b0;
    edges(3);
    check("rst_clean",   32'(sw_if.sw_clean), 32'h00);
    check("rst_strobes", 32'({sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed}), 32'h0);
    @(negedge clk) reset = 1'b1;
    edges(9);
    check("start_pre_clean", 32'(sw_if.sw_clean), 32'h00);
    edges(1);
    check("start_clean",   32'(sw_if.sw_clean),   32'hFF);
    check("start_rise",    32'(sw_if.sw_rise),    32'hFF);
    check("start_changed", 32'(sw_if.sw_changed), 32'h1);
    edges(1);
    check("start_strobe_gone", 32'({sw_if.sw_rise, sw_if.sw_changed}), 32'h0);

    // Bounce on bit 0, then settle high.
    @(negedge clk) sw_if.sw_raw = 8'h00;
    edges(12);
    check("bounce_base", 32'(sw_if.sw_clean), 32'h00);
    rise0_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk) sw_if.sw_raw[0] = ((c / 3) % 2 == 0);
    end
    @(negedge clk) sw_if.sw_raw[0] = 1'b1;
    edges(12);
    check("bounce_rise_pulses", 32'(rise0_cnt), 32'd1);
    check("bounce_clean", 32'(sw_if.sw_clean), 32'h01);

    // Seven-cycle pulse on bit 3 must be rejected.
    chg_cnt = 0;
    @(negedge clk) sw_if.sw_raw[3] = 1'b1;
    repeat (7) @(negedge clk);
    sw_if.sw_raw[3] = 1'b0;
    edges(12);
    check("short_pulse_changes", 32'(chg_cnt), 32'd0);
    check("short_pulse_clean", 32'(sw_if.sw_clean), 32'h01);

    // Simultaneous rise on bit 1 and fall on bit 6.
    @(negedge clk) sw_if.sw_raw = 8'h40;
    edges(12);
    check("simul_base", 32'(sw_if.sw_clean), 32'h40);
    @(negedge clk) sw_if.sw_raw = 8'h02;
    edges(9);
    check("simul_pre_clean", 32'(sw_if.sw_clean), 32'h40);
    edges(1);
    check("simul_clean",   32'(sw_if.sw_clean),   32'h02);
    check("simul_rise",    32'(sw_if.sw_rise),    32'h02);
    check("simul_fall",    32'(sw_if.sw_fall),    32'h40);
    check("simul_changed", 32'(sw_if.sw_changed), 32'h1);
    edges(1);
    check("simul_strobe_gone", 32'({sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed}), 32'h0);

    // Reset while bit 2 is part-way through qualifying.
    @(negedge clk) sw_if.sw_raw = 8'h06;
    edges(7);
    #2 reset = 1'b0;
    #1;
    check("midrst_clean",   32'(sw_if.sw_clean), 32'h00);
    check("midrst_strobes", 32'({sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed}), 32'h0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    edges(9);
    check("midrst_pre_clean", 32'(sw_if.sw_clean), 32'h00);
    edges(1);
    check("midrst_clean_after", 32'(sw_if.sw_clean), 32'h06);
    check("midrst_rise_after",  32'(sw_if.sw_rise),  32'h06);

    // Counter-stage view: 0x00 -> 0x01 through two-cycle glitches.
    @(negedge clk) sw_if.sw_raw = 8'h00;
    edges(12);
    chg_cnt = 0;
    repeat (4) begin
      @(negedge clk) sw_if.sw_raw = 8'h01;
      repeat (2) @(negedge clk);
      sw_if.sw_raw = 8'h00;
      repeat (2) @(negedge clk);
    end
    @(negedge clk) sw_if.sw_raw = 8'h01;
    edges(12);
    check("glitch_changes", 32'(chg_cnt), 32'd1);
    check("glitch_clean", 32'(sw_if.sw_clean), 32'h01);

    // Random activity: hold lengths straddle the qualification window, occasional resets.
    repeat (200) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
      mask = W'($urandom);
      sw_if.sw_raw = (sw_if.sw_raw & ~mask) | (W'($urandom) & mask);
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end

    edges(12);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
